mac_sequencer: RTL and testbench

Controller that sequences the multiply-accumulate datapath for one dot-product transaction. Accepts a start command with a pair count, streams operand pairs into the MAC through a valid/ready handshake, and presents the accumulated result on a second valid/ready handshake. It sits between the operand source (memory reader or host interface) and the result consumer. It owns the accumulator clear/enable sequencing, so the datapath never needs its own control.

---
 rtl/mac_pkg.sv | 15 +
 rtl/mac_datapath.sv | 43 ++++
 rtl/mac_sequencer.sv | 97 +++++++++
 tb/tb_mac_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared MAC definitions: state encodings and default widths.
// Imported by the sequencer and datapath blocks.
package mac_pkg;

  localparam int DATA_W_D = 8;
  localparam int ACC_W_D  = 24;
  localparam int LEN_W_D  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/mac_datapath.sv
// Multiplier plus accumulator register with clear/enable.
// Overflow is sticky until the next clear or reset.
module mac_datapath
  import mac_pkg::*;
#(
  parameter int DATA_W = DATA_W_D,
  parameter int ACC_W  = ACC_W_D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc,
  output logic              overflow
);

  logic [2*DATA_W-1:0] prod;
  logic [ACC_W:0]      sum;

  // Unsigned product, zero-extended; sum keeps the carry bit.
  always_comb begin
    prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    sum  = {1'b0, acc}
         + {{(ACC_W + 1 - 2*DATA_W){1'b0}}, prod};
  end

  // Accumulator and sticky carry-out; clear wins over enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      acc      <= '0;
      overflow <= 1'b0;
    end else if (en) begin
      acc      <= sum[ACC_W-1:0];
      overflow <= overflow | sum[ACC_W];
    end
  end

endmodule

// File: rtl/mac_sequencer.sv
// Dot-product sequencer: start/len command, operand stream in,
// one accumulated result out, all over valid/ready handshakes.
module mac_sequencer
  import mac_pkg::*;
#(
  parameter int DATA_W = DATA_W_D,
  parameter int ACC_W  = ACC_W_D,
  parameter int LEN_W  = LEN_W_D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  result,
  output logic              overflow
);

  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  state_e           state, state_d;
  logic [LEN_W-1:0] cnt, cnt_d;
  logic             clr, en;

  mac_datapath #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_dp (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .en       (en),
    .a        (a),
    .b        (b),
    .acc      (result),
    .overflow (overflow)
  );

  // Next-state, counter update and datapath strobes.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    clr     = 1'b0;
    en      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          clr     = 1'b1;
          cnt_d   = len;
          state_d = (len != '0) ? ACCUM : DONE;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          en    = 1'b1;
          cnt_d = cnt - ONE;
          if (cnt == ONE) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Handshake/status outputs registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      busy      <= (state_d != IDLE);
      in_ready  <= (state_d == ACCUM);
      out_valid <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer (ACC_W=16 instance).
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic        busy;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a, b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  mac_sequencer #(
    .DATA_W (8),
    .ACC_W  (16),
    .LEN_W  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; len = '0;
    in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b0;
    step(); step();
    checks++;
    if ({busy, in_ready, out_valid, overflow} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0000",
               {busy, in_ready, out_valid, overflow});
    end
    checks++;
    if (result !== 16'd0) begin
      errors++;
      $display("FAIL reset_result: got %0d want 0", result);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    start = 1'b1; len = 8'd3;
    step();
    start = 1'b0;
    checks++;
    if ({busy, in_ready, out_valid} !== 3'b110) begin
      errors++;
      $display("FAIL basic_start: got %b want 110",
               {busy, in_ready, out_valid});
    end
    in_valid = 1'b1; a = 8'd2; b = 8'd3;
    step();
    a = 8'd4; b = 8'd5;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_early_valid: got %b want 0", out_valid);
    end
    a = 8'd6; b = 8'd7;
    step();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b10) begin
      errors++;
      $display("FAIL basic_done: got %b want 10",
               {out_valid, in_ready});
    end
    checks++;
    if (result !== 16'd68 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: got %0d/%b want 68/0",
               result, overflow);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if ({busy, out_valid} !== 2'b00) begin
      errors++;
      $display("FAIL basic_idle: got %b want 00", {busy, out_valid});
    end
  endtask

  task automatic test_zero_len();
    start = 1'b1; len = 8'd0;
    step();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({out_valid, in_ready, busy} !== 3'b101) begin
        errors++;
        $display("FAIL zero_flags: got %b want 101",
                 {out_valid, in_ready, busy});
      end
      checks++;
      if (result !== 16'd0 || overflow !== 1'b0) begin
        errors++;
        $display("FAIL zero_result: got %0d/%b want 0/0",
                 result, overflow);
      end
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_release: got %b want 0", out_valid);
    end
  endtask

  task automatic test_overflow();
    start = 1'b1; len = 8'd2;
    step();
    start = 1'b0;
    in_valid = 1'b1; a = 8'd255; b = 8'd255;
    step();
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_first: got %b want 0", overflow);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (result !== 16'd64514 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_result: got %0d/%b want 64514/1",
               result, overflow);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    step();
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky_idle: got %b want 1", overflow);
    end
    start = 1'b1; len = 8'd1;
    step();
    start = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_cleared: got %b want 0", overflow);
    end
    in_valid = 1'b1; a = 8'd1; b = 8'd1;
    step();
    in_valid = 1'b0;
    checks++;
    if (result !== 16'd1 || overflow !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL ovf_next: got %0d/%b/%b want 1/0/1",
               result, overflow, out_valid);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    start = 1'b1; len = 8'd2;
    step();
    start = 1'b0;
    in_valid = 1'b1; a = 8'd3; b = 8'd3;
    step();
    in_valid = 1'b0; a = 8'd9; b = 8'd9;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({in_ready, out_valid} !== 2'b10 || result !== 16'd9) begin
        errors++;
        $display("FAIL bubble_%0d: got %b/%0d want 10/9",
                 i, {in_ready, out_valid}, result);
      end
    end
    in_valid = 1'b1; a = 8'd1; b = 8'd2;
    step();
    in_valid = 1'b0;
    checks++;
    if (result !== 16'd11 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_result: got %0d/%b want 11/1",
               result, out_valid);
    end
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; len = 8'd5;
      in_valid = 1'b1; a = 8'd7; b = 8'd7;
      step();
      checks++;
      if ({out_valid, in_ready} !== 2'b10 || result !== 16'd11 ||
          overflow !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d: got %b/%0d/%b want 10/11/0",
                 i, {out_valid, in_ready}, result, overflow);
      end
    end
    start = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if ({busy, out_valid} !== 2'b00) begin
      errors++;
      $display("FAIL bp_release: got %b want 00", {busy, out_valid});
    end
  endtask

  task automatic test_reset_mid();
    start = 1'b1; len = 8'd4;
    step();
    start = 1'b0;
    in_valid = 1'b1; a = 8'd1; b = 8'd1;
    step();
    a = 8'd2; b = 8'd2;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, in_ready, out_valid, overflow} !== 4'b0000 ||
        result !== 16'd0) begin
      errors++;
      $display("FAIL rst_async: got %b/%0d want 0000/0",
               {busy, in_ready, out_valid, overflow}, result);
    end
    step();
    rst = 1'b0; in_valid = 1'b0;
    step();
    checks++;
    if ({busy, out_valid} !== 2'b00) begin
      errors++;
      $display("FAIL rst_no_result: got %b want 00", {busy, out_valid});
    end
    start = 1'b1; len = 8'd1;
    step();
    start = 1'b0;
    in_valid = 1'b1; a = 8'd5; b = 8'd5;
    step();
    in_valid = 1'b0;
    checks++;
    if (result !== 16'd25 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_after: got %0d/%b want 25/1",
               result, out_valid);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_start_collision();
    start = 1'b1; len = 8'd1;
    step();
    start = 1'b0;
    in_valid = 1'b1; a = 8'd2; b = 8'd2;
    step();
    in_valid = 1'b0;
    checks++;
    if (result !== 16'd4 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL coll_first: got %0d/%b want 4/1",
               result, out_valid);
    end
    out_ready = 1'b1; start = 1'b1; len = 8'd0;
    step();
    out_ready = 1'b0; len = 8'd1;
    checks++;
    if ({busy, out_valid} !== 2'b00) begin
      errors++;
      $display("FAIL coll_ignored: got %b want 00", {busy, out_valid});
    end
    step();
    start = 1'b0;
    checks++;
    if ({busy, in_ready} !== 2'b11) begin
      errors++;
      $display("FAIL coll_accept: got %b want 11", {busy, in_ready});
    end
    in_valid = 1'b1; a = 8'd3; b = 8'd4;
    step();
    in_valid = 1'b0;
    checks++;
    if (result !== 16'd12 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL coll_result: got %0d/%b want 12/1",
               result, out_valid);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_start_collision();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
